// File: rtl/mem_wb_if.sv
// MEM/WB bus: MEM-stage capture fields in, registered write-back fields out.
// The master drives the IN_* side; the pipeline register is the slave.
interface mem_wb_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  IN_valid;
    logic [REG_ADDR_W-1:0] IN_write_addr;
    logic [DATA_W-1:0]     IN_alu_out;
    logic [DATA_W-1:0]     IN_dmem_out;
    logic [DATA_W-1:0]     IN_pc4;
    logic [1:0]            IN_wbsel;
    logic                  IN_reg_write_en;

    logic                  OUT_valid;
    logic [REG_ADDR_W-1:0] OUT_write_addr;
    logic [DATA_W-1:0]     OUT_wb_data;
    logic [1:0]            OUT_wbsel;
    logic                  OUT_reg_write_en;
    logic [31:0]           OUT_stall_cnt;
    logic [31:0]           OUT_retire_cnt;

    modport master (
        output IN_valid, IN_write_addr, IN_alu_out, IN_dmem_out, IN_pc4, IN_wbsel, IN_reg_write_en,
        input  OUT_valid, OUT_write_addr, OUT_wb_data, OUT_wbsel, OUT_reg_write_en,
               OUT_stall_cnt, OUT_retire_cnt
    );

    modport slave (
        input  IN_valid, IN_write_addr, IN_alu_out, IN_dmem_out, IN_pc4, IN_wbsel, IN_reg_write_en,
        output OUT_valid, OUT_write_addr, OUT_wb_data, OUT_wbsel, OUT_reg_write_en,
               OUT_stall_cnt, OUT_retire_cnt
    );
endinterface

// File: rtl/mem_wb_pipe_reg.sv
// DEPTH-stage MEM/WB pipeline register with stall, flush, x0 suppression and built-in WB mux.
// Define MEM_WB_PERF_CNT_EN to add saturating stall / retire counters.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     busywait,
    input  logic     flush,
    mem_wb_if.slave  bus
);
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("mem_wb_pipe_reg: DEPTH must be in 1..4");
    end

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wb_data;
        logic [1:0]            wbsel;
        logic                  wr_en;
    } stage_t;

    stage_t           cap;
    stage_t           stg [1:DEPTH];
    logic [DEPTH:1]   vld_pipe;

    // Source select resolved at capture so each stage carries one data word.
    always_comb begin
        cap         = '0;
        cap.addr    = bus.IN_write_addr;
        cap.wbsel   = bus.IN_wbsel;
        cap.wr_en   = bus.IN_reg_write_en & bus.IN_valid & (bus.IN_write_addr != '0);
        case (bus.IN_wbsel)
            2'b01:   cap.wb_data = bus.IN_dmem_out;
            2'b10:   cap.wb_data = bus.IN_pc4;
            default: cap.wb_data = bus.IN_alu_out;
        endcase
    end

    // Reset and flush clear identically, so they share one branch ahead of the stall.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            vld_pipe <= '0;
            for (int i = 1; i <= DEPTH; i++) stg[i] <= '0;
        end else if (!busywait) begin
            vld_pipe[1] <= bus.IN_valid;
            stg[1]      <= cap;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                stg[i]      <= stg[i-1];
            end
        end
    end

    assign bus.OUT_valid        = vld_pipe[DEPTH];
    assign bus.OUT_write_addr   = stg[DEPTH].addr;
    assign bus.OUT_wb_data      = stg[DEPTH].wb_data;
    assign bus.OUT_wbsel        = stg[DEPTH].wbsel;
    assign bus.OUT_reg_write_en = stg[DEPTH].wr_en & vld_pipe[DEPTH];

`ifdef MEM_WB_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (!flush && busywait && (|vld_pipe) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (!flush && !busywait && vld_pipe[DEPTH] && (retire_cnt != '1))
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign bus.OUT_stall_cnt  = stall_cnt;
    assign bus.OUT_retire_cnt = retire_cnt;
`else
    assign bus.OUT_stall_cnt  = 32'd0;
    assign bus.OUT_retire_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench: DEPTH 1/2/3 instances on shared stimulus, each against a queue model of the MEM/WB register.
module tb_mem_wb_pipe_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ND = 3;
`ifdef MEM_WB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0, busywait = 1'b0, flush = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_we;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_alu, in_dmem, in_pc4;
    logic [1:0]    in_wbsel;

    logic [ND-1:0]          o_valid, o_we;
    logic [ND-1:0][AW-1:0]  o_addr;
    logic [ND-1:0][DW-1:0]  o_data;
    logic [ND-1:0][1:0]     o_wbsel;
    logic [ND-1:0][31:0]    o_stall, o_retire;

    mem_wb_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus [ND] ();

    for (genvar g = 0; g < ND; g++) begin : g_dut
        assign bus[g].IN_valid        = in_valid;
        assign bus[g].IN_write_addr   = in_addr;
        assign bus[g].IN_alu_out      = in_alu;
        assign bus[g].IN_dmem_out     = in_dmem;
        assign bus[g].IN_pc4          = in_pc4;
        assign bus[g].IN_wbsel        = in_wbsel;
        assign bus[g].IN_reg_write_en = in_we;

        mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .DEPTH(g + 1)) dut (
            .clk      (clk),
            .reset    (reset),
            .busywait (busywait),
            .flush    (flush),
            .bus      (bus[g])
        );

        assign o_valid[g]  = bus[g].OUT_valid;
        assign o_addr[g]   = bus[g].OUT_write_addr;
        assign o_data[g]   = bus[g].OUT_wb_data;
        assign o_wbsel[g]  = bus[g].OUT_wbsel;
        assign o_we[g]     = bus[g].OUT_reg_write_en;
        assign o_stall[g]  = bus[g].OUT_stall_cnt;
        assign o_retire[g] = bus[g].OUT_retire_cnt;
    end

    // Reference: each instance is a queue of DEPTH entries; front = newest, back = output.
    typedef struct {
        bit          valid;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;
        bit [1:0]    wbsel;
        bit          we;
    } ent_t;

    ent_t        mq [ND][$];
    int unsigned exp_stall [ND];
    int unsigned exp_retire [ND];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [DW-1:0] wb_pick(bit [1:0] sel, bit [DW-1:0] alu, bit [DW-1:0] dmem, bit [DW-1:0] pc4);
        if (sel == 2'b01) return dmem;
        if (sel == 2'b10) return pc4;
        return alu;
    endfunction

    task automatic model_clear(input int d);
        ent_t z;
        z = '{valid: 1'b0, addr: '0, data: '0, wbsel: '0, we: 1'b0};
        mq[d].delete();
        for (int k = 0; k <= d; k++) mq[d].push_back(z);
    endtask

    task automatic model_edge();
        ent_t ne;
        ne.valid = in_valid;
        ne.addr  = in_addr;
        ne.data  = wb_pick(in_wbsel, in_alu, in_dmem, in_pc4);
        ne.wbsel = in_wbsel;
        ne.we    = in_we && in_valid && (in_addr != 0);
        for (int d = 0; d < ND; d++) begin
            bit anyv = 1'b0;
            for (int k = 0; k < mq[d].size(); k++) anyv |= mq[d][k].valid;
            if (!reset) begin
                model_clear(d);
                exp_stall[d]  = 0;
                exp_retire[d] = 0;
            end else if (flush) begin
                model_clear(d);
            end else if (busywait) begin
                if (anyv && exp_stall[d] != 32'hFFFF_FFFF) exp_stall[d]++;
            end else begin
                if (mq[d][$].valid && exp_retire[d] != 32'hFFFF_FFFF) exp_retire[d]++;
                mq[d].push_front(ne);
                void'(mq[d].pop_back());
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < ND; d++) begin
            ent_t t;
            t = mq[d][$];
            chk($sformatf("d%0d valid", d + 1), 32'(o_valid[d]), 32'(t.valid));
            chk($sformatf("d%0d addr", d + 1), 32'(o_addr[d]), 32'(t.addr));
            chk($sformatf("d%0d data", d + 1), o_data[d], t.data);
            chk($sformatf("d%0d wbsel", d + 1), 32'(o_wbsel[d]), 32'(t.wbsel));
            chk($sformatf("d%0d we", d + 1), 32'(o_we[d]), 32'(t.we && t.valid));
            chk($sformatf("d%0d stall_cnt", d + 1), o_stall[d], PERF ? exp_stall[d] : 32'd0);
            chk($sformatf("d%0d retire_cnt", d + 1), o_retire[d], PERF ? exp_retire[d] : 32'd0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit v, input bit [AW-1:0] a, input bit [DW-1:0] alu,
                          input bit [DW-1:0] dmem, input bit [DW-1:0] pc4, input bit [1:0] sel, input bit we);
        in_valid = v; in_addr = a; in_alu = alu; in_dmem = dmem; in_pc4 = pc4; in_wbsel = sel; in_we = we;
    endtask

    task automatic set_rand(input bit v);
        bit [AW-1:0] a;
        a = ($urandom_range(3) == 0) ? '0 : AW'($urandom);
        set_in(v, a, $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom));
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        set_rand(1'b1);
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            model_clear(d);
            exp_stall[d]  = 0;
            exp_retire[d] = 0;
        end
        set_rand(1'b1);

        // T1: reset held two edges with live input
        reset = 1'b0;
        cycle();
        set_rand(1'b1);
        cycle();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("t1 d%0d valid", d + 1), 32'(o_valid[d]), 32'd0);
            chk($sformatf("t1 d%0d data", d + 1), o_data[d], 32'd0);
            chk($sformatf("t1 d%0d stall", d + 1), o_stall[d], 32'd0);
        end
        reset = 1'b1;

        // T2: DEPTH=3 latency
        set_in(1'b1, 5, 32'h1234, $urandom, $urandom, 2'b00, 1'b1);
        cycle();
        set_rand(1'b0);
        cycle();
        cycle();
        chk("t2 data", o_data[2], 32'h1234);
        chk("t2 addr", 32'(o_addr[2]), 32'd5);
        chk("t2 we", 32'(o_we[2]), 32'd1);
        cycle();
        chk("t2 we one cycle", 32'(o_we[2]), 32'd0);

        // T3: DEPTH=1 stall hold
        reset_pulse();
        set_in(1'b1, 7, $urandom, 32'hCAFE, $urandom, 2'b01, 1'b1);
        cycle();
        busywait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_rand(1'b1);
            cycle();
            chk("t3 hold", o_data[0], 32'hCAFE);
        end
        chk("t3 stall_cnt", o_stall[0], PERF ? 32'd4 : 32'd0);
        busywait = 1'b0;

        // T4: x0 write suppression
        set_in(1'b1, 0, $urandom, $urandom, $urandom, 2'b00, 1'b1);
        cycle();
        chk("t4 valid", 32'(o_valid[0]), 32'd1);
        chk("t4 we", 32'(o_we[0]), 32'd0);

        // T5: DEPTH=2 flush together with busywait
        set_in(1'b1, 3, $urandom, $urandom, $urandom, 2'b00, 1'b1);
        cycle();
        set_in(1'b1, 4, $urandom, $urandom, $urandom, 2'b00, 1'b1);
        cycle();
        chk("t5 pre valid", 32'(o_valid[1]), 32'd1);
        flush = 1'b1;
        busywait = 1'b1;
        set_rand(1'b1);
        cycle();
        chk("t5 valid", 32'(o_valid[1]), 32'd0);
        chk("t5 we", 32'(o_we[1]), 32'd0);
        flush = 1'b0;
        busywait = 1'b0;
        set_rand(1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5 no reappear", 32'(o_valid[1]), 32'd0);
        end

        // T6: link select and retire count
        reset_pulse();
        set_in(1'b1, 9, $urandom, $urandom, 32'h0000_0104, 2'b10, 1'b1);
        cycle();
        set_rand(1'b0);
        cycle();
        cycle();
        chk("t6 data", o_data[2], 32'h0000_0104);
        chk("t6 valid", 32'(o_valid[2]), 32'd1);
        cycle();
        chk("t6 retire_cnt", o_retire[2], PERF ? 32'd1 : 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(99) != 0);
            flush    = ($urandom_range(19) == 0);
            busywait = ($urandom_range(3) == 0);
            set_rand($urandom_range(4) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
